// File: rtl/chiplib_pri_queue_pkg.sv
// Shared constants and helpers for the chiplib priority-queue blocks.
// Latency: none; declarations only.
// Backpressure: not applicable.
package chiplib_pri_queue_pkg;

  localparam int PopCountWidth = 32;

  // Skid buffer depth: slot0 drives the output, slot1 absorbs one stalled pop.
  localparam logic [1:0] SkidDepth = 2'd2;

  // Pacing gate: either pacing is off or the interval counter has run out.
  function automatic logic pace_allows(input logic pace_en, input logic pcnt_zero);
    return !pace_en || pcnt_zero;
  endfunction

endpackage

// File: rtl/chiplib_skid_buf.sv
// Two-entry registered valid/ready buffer; slot0 drives the output, slot1 is the skid slot.
// Latency: a push is visible on vld_o/dat_o the cycle after it is written.
// Backpressure: holds dat_o stable while rdy_i=0; the writer must not push when full.
module chiplib_skid_buf
  import chiplib_pri_queue_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] push_dat_i,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic [Width-1:0] dat_o,
  output logic [1:0]       occ_o
);

  logic [1:0]       occ_q, occ_d, occ_after;
  logic [Width-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic             fire;

  assign vld_o = (occ_q != 2'd0);
  assign dat_o = slot0_q;
  assign occ_o = occ_q;
  assign fire  = vld_o && rdy_i;

  // Apply the output fire first (shift slot1 down), then write the push into the new tail.
  always_comb begin
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    occ_after = occ_q;
    if (fire) begin
      slot0_d   = slot1_q;
      occ_after = occ_q - 2'd1;
    end
    if (push_i) begin
      if (occ_after == 2'd0) begin
        slot0_d = push_dat_i;
      end else begin
        slot1_d = push_dat_i;
      end
    end
    occ_d = occ_after + {1'b0, push_i};
  end

  // Occupancy is the only state that needs reset; slot contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= 2'd0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Slot data registers.
  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  a_occ_max: assert property (@(posedge clk) disable iff (rst) occ_q <= SkidDepth);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && (occ_q == SkidDepth) && !fire));

endmodule

// File: rtl/chiplib_pri_queue_egress.sv
// Drains the priority-queue head into a registered valid/ready stream, with optional pop pacing.
// Latency: queue head to out_valid is 1 cycle.
// Backpressure: out_ready only stalls the 2-entry buffer; pops stop once it is full, never combinationally.
module chiplib_pri_queue_egress
  import chiplib_pri_queue_pkg::*;
#(
  parameter int DataWidth     = 64,
  parameter int PriorityWidth = 16,
  parameter int PaceWidth     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     q_empty,
  input  logic [DataWidth-1:0]     q_data,
  input  logic [PriorityWidth-1:0] q_pri,
  output logic                     q_pop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DataWidth-1:0]     out_data,
  output logic [PriorityWidth-1:0] out_pri,
  input  logic                     cfg_pace_en,
  input  logic [PaceWidth-1:0]     cfg_pace_interval,
  output logic [PopCountWidth-1:0] pop_count
);

  typedef struct packed {
    logic [PriorityWidth-1:0] pri;
    logic [DataWidth-1:0]     data;
  } entry_t;

  entry_t                   head_ent, out_ent;
  logic [1:0]               occ;
  logic                     pace_ok;
  logic [PaceWidth-1:0]     pcnt_q, pcnt_d, pace_load;
  logic [PopCountWidth-1:0] pop_count_q, pop_count_d;

  assign head_ent = '{pri: q_pri, data: q_data};
  assign pace_ok  = pace_allows(cfg_pace_en, pcnt_q == '0);
  assign q_pop    = !rst && !q_empty && (occ < SkidDepth) && pace_ok;

  // Interval 0 and 1 both mean "every cycle", so the reload saturates at zero.
  assign pace_load = (cfg_pace_interval == '0) ? '0 : cfg_pace_interval - PaceWidth'(1);

  chiplib_skid_buf #(
    .Width($bits(entry_t))
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (q_pop),
    .push_dat_i (head_ent),
    .vld_o      (out_valid),
    .rdy_i      (out_ready),
    .dat_o      (out_ent),
    .occ_o      (occ)
  );

  assign out_data  = out_ent.data;
  assign out_pri   = out_ent.pri;
  assign pop_count = pop_count_q;

  // Reload the pacing counter on every pop, otherwise count down to zero; bump the pop counter.
  always_comb begin
    pcnt_d      = pcnt_q;
    pop_count_d = pop_count_q;
    if (q_pop) begin
      pcnt_d      = pace_load;
      pop_count_d = pop_count_q + PopCountWidth'(1);
    end else if (pcnt_q != '0) begin
      pcnt_d = pcnt_q - PaceWidth'(1);
    end
  end

  // Pacing counter and wrapping pop counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q      <= '0;
      pop_count_q <= '0;
    end else begin
      pcnt_q      <= pcnt_d;
      pop_count_q <= pop_count_d;
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(q_pop && q_empty));
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_pri)));

endmodule

// File: tb/tb_chiplib_pri_queue_egress.sv
module tb_chiplib_pri_queue_egress;
  localparam int DW = 64;
  localparam int PW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, q_empty, q_pop, out_valid, out_ready, cfg_pace_en;
  logic [DW-1:0] q_data, out_data;
  logic [PW-1:0] q_pri, out_pri;
  logic [CW-1:0] cfg_pace_interval;
  logic [31:0]   pop_count;

  always #5 clk = ~clk;

  chiplib_pri_queue_egress #(.DataWidth(DW), .PriorityWidth(PW), .PaceWidth(CW)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_data(q_data), .q_pri(q_pri),
    .q_pop(q_pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_pri(out_pri), .cfg_pace_en(cfg_pace_en),
    .cfg_pace_interval(cfg_pace_interval), .pop_count(pop_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int seq   = 0;

  // Upstream queue model: sorted by descending priority, FIFO among equals.
  logic [PW-1:0]    mq_pri[$];
  logic [DW-1:0]    mq_dat[$];
  // Scoreboard of entries popped but not yet delivered.
  logic [PW+DW-1:0] exp_q[$];
  int               pop_cyc[$];
  int               fire_cyc[$];
  logic [PW-1:0]    fire_pri[$];

  task automatic drive_head();
    if (mq_pri.size() == 0) begin
      q_empty = 1'b1; q_pri = '0; q_data = '0;
    end else begin
      q_empty = 1'b0; q_pri = mq_pri[0]; q_data = mq_dat[0];
    end
  endtask

  task automatic push_q(input logic [PW-1:0] p);
    int idx;
    logic found;
    logic [DW-1:0] d;
    d = {32'(seq), 16'hA5A5, p};
    seq++;
    idx = mq_pri.size();
    found = 1'b0;
    for (int i = 0; i < mq_pri.size(); i++) begin
      if (!found && mq_pri[i] < p) begin idx = i; found = 1'b1; end
    end
    mq_pri.insert(idx, p);
    mq_dat.insert(idx, d);
    drive_head();
  endtask

  task automatic clear_logs();
    pop_cyc.delete(); fire_cyc.delete(); fire_pri.delete();
  endtask

  // One clock cycle: sample at negedge+1, score fire then pop, advance the queue model.
  task automatic step();
    logic pop_s, fire_s, rst_s;
    logic [PW+DW-1:0] got, exp;
    #1;
    pop_s  = q_pop;
    fire_s = out_valid && out_ready;
    rst_s  = rst;
    if (fire_s && !rst_s) begin
      fire_cyc.push_back(cyc);
      fire_pri.push_back(out_pri);
      got = {out_pri, out_data};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow cyc=%0d: output pri=%0d fired, expected no output", cyc, out_pri);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL sb_order cyc=%0d: got %h, expected %h", cyc, got, exp);
        end
      end
    end
    if (pop_s) begin
      n_cmp++;
      if (mq_pri.size() == 0) begin
        n_err++;
        $display("FAIL pop_empty cyc=%0d: q_pop=1 with queue empty, expected 0", cyc);
      end else begin
        exp_q.push_back({mq_pri[0], mq_dat[0]});
        pop_cyc.push_back(cyc);
        void'(mq_pri.pop_front());
        void'(mq_dat.pop_front());
      end
    end
    if (rst_s) exp_q.delete();
    @(posedge clk);
    #1;
    drive_head();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    push_q(16'd7);
    step(); step();
    n_cmp++; if (q_pop !== 1'b0) begin n_err++; $display("FAIL rst_q_pop: got %b, expected 0", q_pop); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    n_cmp++; if (pop_count !== 32'd0) begin n_err++; $display("FAIL rst_pop_count: got %0d, expected 0", pop_count); end
    mq_pri.delete(); mq_dat.delete(); drive_head();
    rst = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || q_pop !== 1'b0) begin
      n_err++; $display("FAIL idle_after_rst: out_valid=%b q_pop=%b, expected 0 0", out_valid, q_pop);
    end
  endtask

  task automatic test_basic();
    int c0;
    logic [PW-1:0] ep[3];
    ep = '{16'd9, 16'd5, 16'd3};
    clear_logs();
    out_ready = 1'b1;
    push_q(16'd3); push_q(16'd9); push_q(16'd5);
    c0 = cyc;
    repeat (6) step();
    n_cmp++;
    if (pop_cyc.size() != 3 || fire_pri.size() != 3) begin
      n_err++; $display("FAIL basic_counts: pops=%0d fires=%0d, expected 3 3", pop_cyc.size(), fire_pri.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (pop_cyc[i] != c0 + i) begin n_err++; $display("FAIL basic_pop_cyc[%0d]: got %0d, expected %0d", i, pop_cyc[i], c0 + i); end
        n_cmp++; if (fire_pri[i] !== ep[i]) begin n_err++; $display("FAIL basic_pri[%0d]: got %0d, expected %0d", i, fire_pri[i], ep[i]); end
        n_cmp++; if (fire_cyc[i] != c0 + i + 1) begin n_err++; $display("FAIL basic_lat[%0d]: got %0d, expected %0d", i, fire_cyc[i], c0 + i + 1); end
      end
    end
    n_cmp++; if (pop_count !== 32'd3) begin n_err++; $display("FAIL basic_pop_count: got %0d, expected 3", pop_count); end
  endtask

  task automatic test_backpressure();
    int cr;
    logic [PW-1:0] ep[4];
    ep = '{16'd8, 16'd7, 16'd6, 16'd5};
    clear_logs();
    out_ready = 1'b0;
    push_q(16'd5); push_q(16'd6); push_q(16'd7); push_q(16'd8);
    repeat (6) step();
    n_cmp++; if (pop_cyc.size() != 2) begin n_err++; $display("FAIL bp_pops: got %0d, expected 2", pop_cyc.size()); end
    n_cmp++; if (q_pop !== 1'b0) begin n_err++; $display("FAIL bp_q_pop: got %b, expected 0", q_pop); end
    n_cmp++; if (out_valid !== 1'b1 || out_pri !== 16'd8) begin
      n_err++; $display("FAIL bp_hold: valid=%b pri=%0d, expected 1 8", out_valid, out_pri);
    end
    n_cmp++; if (pop_count !== 32'd5) begin n_err++; $display("FAIL bp_pop_count: got %0d, expected 5", pop_count); end
    clear_logs();
    out_ready = 1'b1;
    cr = cyc;
    repeat (8) step();
    n_cmp++;
    if (fire_pri.size() != 4) begin
      n_err++; $display("FAIL bp_drain: got %0d fires, expected 4", fire_pri.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (fire_pri[i] !== ep[i]) begin n_err++; $display("FAIL bp_pri[%0d]: got %0d, expected %0d", i, fire_pri[i], ep[i]); end
      end
    end
    n_cmp++;
    if (pop_cyc.size() != 2 || pop_cyc[0] != cr + 1 || pop_cyc[1] != cr + 2) begin
      n_err++; $display("FAIL bp_resume: pops=%0d first=%0d, expected 2 at %0d", pop_cyc.size(),
                        (pop_cyc.size() > 0) ? pop_cyc[0] : -1, cr + 1);
    end
  endtask

  task automatic test_pacing();
    int c0;
    clear_logs();
    out_ready = 1'b1; cfg_pace_en = 1'b1; cfg_pace_interval = 8'd4;
    for (int i = 0; i < 5; i++) push_q(16'(20 - i));
    c0 = cyc;
    repeat (20) step();
    n_cmp++;
    if (pop_cyc.size() != 5) begin
      n_err++; $display("FAIL pace_pops: got %0d, expected 5", pop_cyc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (pop_cyc[i] != c0 + 4 * i) begin n_err++; $display("FAIL pace_cyc[%0d]: got %0d, expected %0d", i, pop_cyc[i], c0 + 4 * i); end
      end
    end
    n_cmp++; if (pop_count !== 32'd12) begin n_err++; $display("FAIL pace_pop_count: got %0d, expected 12", pop_count); end
    cfg_pace_en = 1'b0;
  endtask

  task automatic test_pace_zero();
    int c0;
    clear_logs();
    out_ready = 1'b1; cfg_pace_en = 1'b1; cfg_pace_interval = 8'd0;
    for (int i = 0; i < 4; i++) push_q(16'(30 + i));
    c0 = cyc;
    repeat (6) step();
    n_cmp++;
    if (pop_cyc.size() != 4) begin
      n_err++; $display("FAIL pz_pops: got %0d, expected 4", pop_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (pop_cyc[i] != c0 + i) begin n_err++; $display("FAIL pz_cyc[%0d]: got %0d, expected %0d", i, pop_cyc[i], c0 + i); end
      end
    end
    cfg_pace_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c0;
    clear_logs();
    out_ready = 1'b0; cfg_pace_en = 1'b1; cfg_pace_interval = 8'd5;
    for (int i = 0; i < 4; i++) push_q(16'(40 + i));
    c0 = cyc;
    repeat (6) step();
    n_cmp++;
    if (pop_cyc.size() != 2 || pop_cyc[1] != c0 + 5) begin
      n_err++; $display("FAIL rm_fill: pops=%0d, expected 2 with second at %0d", pop_cyc.size(), c0 + 5);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (q_pop !== 1'b0) begin n_err++; $display("FAIL rm_pop_in_rst: got %b, expected 0", q_pop); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b, expected 0", out_valid); end
    n_cmp++; if (pop_count !== 32'd0) begin n_err++; $display("FAIL rm_pop_count: got %0d, expected 0", pop_count); end
    n_cmp++; if (q_pop !== 1'b1) begin n_err++; $display("FAIL rm_pop_resume: got %b, expected 1", q_pop); end
    cfg_pace_en = 1'b0; out_ready = 1'b1;
    clear_logs();
    repeat (5) step();
    n_cmp++;
    if (fire_pri.size() != 2 || fire_pri[0] !== 16'd41 || fire_pri[1] !== 16'd40) begin
      n_err++; $display("FAIL rm_drain: got %0d fires, expected 41 then 40", fire_pri.size());
    end
    n_cmp++; if (pop_count !== 32'd2) begin n_err++; $display("FAIL rm_count2: got %0d, expected 2", pop_count); end
  endtask

  task automatic test_no_preempt();
    logic [PW-1:0] ep[3];
    ep = '{16'd5, 16'd3, 16'd15};
    clear_logs();
    out_ready = 1'b0;
    push_q(16'd5); push_q(16'd3);
    repeat (3) step();
    push_q(16'd15);
    repeat (2) step();
    n_cmp++; if (q_pop !== 1'b0) begin n_err++; $display("FAIL np_full: q_pop=%b, expected 0", q_pop); end
    out_ready = 1'b1;
    repeat (6) step();
    n_cmp++;
    if (fire_pri.size() != 3) begin
      n_err++; $display("FAIL np_count: got %0d fires, expected 3", fire_pri.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (fire_pri[i] !== ep[i]) begin n_err++; $display("FAIL np_pri[%0d]: got %0d, expected %0d", i, fire_pri[i], ep[i]); end
      end
    end
    n_cmp++; if (pop_count !== 32'd5) begin n_err++; $display("FAIL np_pop_count: got %0d, expected 5", pop_count); end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; cfg_pace_en = 1'b0; cfg_pace_interval = 8'd0;
    drive_head();
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_pacing();
    test_pace_zero();
    test_reset_mid();
    test_no_preempt();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d entries undelivered, expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
